// File: rtl/ps2_mouse_position.sv
// ps2_mouse_position: receive-only PS/2 mouse front end.
// Deserialises 11-bit device-to-host frames, assembles 3-byte movement
// packets and accumulates the X/Y deltas into saturating 8-bit positions.
module ps2_mouse_position #(
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] X_INIT         = 8'h80,
  parameter logic [7:0] Y_INIT         = 8'h80
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] XPosition,
  output logic [7:0] YPosition,
  output logic [2:0] buttons,
  output logic       packet_valid,
  output logic       frame_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, STOP} state_t;

  // Saturating accumulate of a 9-bit two's complement delta onto a 0..255 position.
  // An overflowed axis contributes nothing.
  function automatic logic [7:0] sat_add(input logic [7:0] pos, input logic sign,
                                         input logic [7:0] mag, input logic ovf);
    logic signed [9:0] delta;
    logic signed [9:0] sum;
    delta = ovf ? 10'sd0 : $signed({sign, sign, mag});
    sum   = $signed({2'b00, pos}) + delta;
    if (sum < 10'sd0)
      return 8'h00;
    else if (sum > 10'sd255)
      return 8'hFF;
    else
      return sum[7:0];
  endfunction

  logic            clk_s1, clk_s2, clk_s3;
  logic            dat_s1, dat_s2;
  logic            fall;
  state_t          state;
  logic [3:0]      bit_cnt;
  logic [TW-1:0]   timer;
  logic [8:0]      shreg;
  logic            tmo;
  logic            byte_ok;
  logic            byte_bad;
  logic            frame_abort;
  logic [1:0]      idx;
  logic [6:0]      hdr_p0;   // {Yovf, Xovf, Ysign, Xsign, M, R, L}
  logic [7:0]      xdat_p0;
  logic [7:0]      ydat_p1;
  logic            vld_p1;

  // Two-flop synchronisers plus one history flop for falling-edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_s3 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  assign fall        = clk_s3 & ~clk_s2;
  assign tmo         = (state != IDLE) && !fall && (timer == TW'(TIMEOUT_CYCLES - 1));
  assign byte_ok     = fall && (state == STOP) && dat_s2 && (^shreg);
  assign byte_bad    = fall && (state == STOP) && !(dat_s2 && (^shreg));
  assign frame_abort = byte_bad | tmo;

  // Frame receiver FSM with mid-frame inactivity timeout; frame_error is registered here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= 4'd0;
      timer       <= '0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      if (fall || state == IDLE)
        timer <= '0;
      else
        timer <= timer + TW'(1);
      case (state)
        IDLE: begin
          if (fall && !dat_s2) begin
            state   <= SHIFT;
            bit_cnt <= 4'd0;
          end
        end
        SHIFT: begin
          if (fall) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd8)
              state <= STOP;
          end
        end
        STOP: begin
          if (fall) begin
            state <= IDLE;
            if (byte_bad)
              frame_error <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (tmo) begin
        state       <= IDLE;
        timer       <= '0;
        frame_error <= 1'b1;
      end
    end
  end

  // Data and parity shift register, LSB first; after nine shifts [7:0] is the byte and [8] the parity.
  always_ff @(posedge clock) begin
    if (state == SHIFT && fall)
      shreg <= {dat_s2, shreg[8:1]};
  end

  // Packet byte index; resyncs on header bit3 and restarts on any frame error.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx    <= 2'd0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (frame_abort) begin
        idx <= 2'd0;
      end else if (byte_ok) begin
        case (idx)
          2'd0:    if (shreg[3]) idx <= 2'd1;
          2'd1:    idx <= 2'd2;
          2'd2: begin
            idx    <= 2'd0;
            vld_p1 <= 1'b1;
          end
          default: idx <= 2'd0;
        endcase
      end
    end
  end

  // Packet byte capture, selected by the current index.
  always_ff @(posedge clock) begin
    if (byte_ok) begin
      case (idx)
        2'd0:    hdr_p0  <= {shreg[7:4], shreg[2:0]};
        2'd1:    xdat_p0 <= shreg[7:0];
        2'd2:    ydat_p1 <= shreg[7:0];
        default: ;
      endcase
    end
  end

  // ---- commit stage: packet_valid, buttons and positions update together ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      XPosition    <= X_INIT;
      YPosition    <= Y_INIT;
      buttons      <= 3'b000;
      packet_valid <= 1'b0;
    end else begin
      packet_valid <= vld_p1;
      if (vld_p1) begin
        XPosition <= sat_add(XPosition, hdr_p0[3], xdat_p0, hdr_p0[5]);
        YPosition <= sat_add(YPosition, hdr_p0[4], ydat_p1, hdr_p0[6]);
        buttons   <= hdr_p0[2:0];
      end
    end
  end

endmodule
